gate_bist_ctrl: RTL
===================

# gate_bist_ctrl

Built-in self-test sequencer for the two-input basic-gates unit (NOT A, NOT B, BUF, AND, OR, NAND, NOR, XOR, XNOR). On a start pulse it drives all four (a,b) input combinations into the unit, holds each for a programmable settle time, and captures and checks the nine gate outputs against the truth table. It reports per-gate and per-vector failures plus an overall pass flag. It sits between the test/config logic and the gate unit's `a_in`/`b_in`/result pins.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before the check cycle; legal range 1..255 (8-bit counter).
- `clk_in` in 1: single clock, rising edge.
- `rst_in` in 1: reset, **synchronous, active-high**.
- `start_in` in 1: start request, sampled only in IDLE.
- `a_out` in→out 1: drives the gate unit's `a_in`.
- `b_out` out 1: drives the gate unit's `b_in`.
- `gate_res_in` in 9: gate unit outputs `{not_a, not_b, buf, and, or, nand, nor, xor, xnor}`, bit 8 down to bit 0.
- `busy_out` out 1: test in progress.
- `done_out` out 1: one-cycle completion pulse.
- `pass_out` out 1: sticky result, valid from `done_out` until the next start.
- `fail_mask_out` out 9: OR-accumulated mismatch bits, same order as `gate_res_in`.
- `fail_vec_out` out 4: bit v set if vector v = {a,b} had any mismatch.

## Operation
- States: IDLE, SETTLE, CHECK, DONE. Vector index v is 2 bits; `a_out = v[1]`, `b_out = v[0]`.
- IDLE:
  - `start_in = 1` → v <= 0; `fail_mask_out`, `fail_vec_out` and `pass_out` cleared; settle counter <= SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: counter decrements each cycle; at 0 → CHECK.
- CHECK: compare `gate_res_in` with expected `{~a, ~b, a, a&b, a|b, ~(a&b), ~(a|b), a^b, ~(a^b)}`.
  - `fail_mask_out |= mismatch`.
  - `fail_vec_out[v] <= |mismatch`.
  - If v < 3: v <= v+1, reload the counter, go to SETTLE.
  - If v = 3: go to DONE.
- DONE, one cycle:
  - `done_out = 1`.
  - `pass_out <= 1` iff the accumulated mask (including the v=3 check) is zero.
  - Go to IDLE.
- `busy_out = 1` in SETTLE, CHECK and DONE; 0 in IDLE.
- `start_in` is ignored while `busy_out = 1`, including the DONE cycle.
- `pass_out`, `fail_mask_out`, `fail_vec_out` and `a_out`/`b_out` (vector 3) hold after DONE until the next start or reset.
- `gate_res_in` is assumed 0/1; X/Z inputs are out of scope for the bench.

## Timing
- All outputs are registered.
- Reset values: `a_out = 0`, `b_out = 0`, `busy_out = 0`, `done_out = 0`, `pass_out = 0`, `fail_mask_out = 0`, `fail_vec_out = 0`; state IDLE.
- `rst_in` during any state: the cycle after the edge shows the reset values, and the run is abandoned.
- `rst_in` and `start_in` on the same edge: reset wins.
- Start accepted at edge t0:
  - Vector 0 is on `a_out`/`b_out` from t0.
  - Vector v is sampled at edge t0 + (v+1)(S+1), where S = SETTLE_CYCLES. Each vector is held S+1 cycles before sampling.
  - `done_out` is high in the cycle following edge t0 + 4(S+1).
  - IDLE is re-entered one edge later; total busy time is 4(S+1)+1 cycles.
- A new start can be accepted on the first edge after return to IDLE.

## Test plan
- Fault-free gate model, S=2, start at t0:
  - `a_out`/`b_out` = 00, 01, 10, 11, changing at t0, t0+3, t0+6, t0+9.
  - `done_out` high for exactly one cycle after edge t0+12.
  - `pass_out = 1`, `fail_mask_out = 9'h000`, `fail_vec_out = 4'b0000`; `busy_out` high for 13 cycles.
- XOR output stuck-at-0 → `fail_mask_out = 9'h002`, `fail_vec_out = 4'b0110`, `pass_out = 0`.
- AND output stuck-at-1 → `fail_mask_out = 9'h020`, `fail_vec_out = 4'b0111`, `pass_out = 0`.
- `start_in` held high for the whole run → exactly one run; `done_out` is still at edge t0+12 plus one cycle.
  - A second start accepted immediately in IDLE then runs cleanly.
- `rst_in` asserted while v = 2 → next cycle all outputs zero, state IDLE. A following start with a fault-free model gives `pass_out = 1`.
- Failing run (XOR stuck) then fault-free run → second start clears flags at acceptance. Final `pass_out = 1`, `fail_mask_out = 0`.
  - Repeat with S=1: samples at edges t0+2, 4, 6, 8.

Source files
------------

// File: rtl/gate_bist_ctrl_if.sv
// rtl/gate_bist_ctrl_if.sv - signal bundle between the BIST sequencer, its test/config logic and the gate unit
//
// Purpose: groups the start request, vector drive, gate result capture and
// test status signals of gate_bist_ctrl into one interface.
//
// Signals:
//   start_in      test/config -> BIST   start request
//   a_out, b_out  BIST -> gate unit     drive the gate unit a_in / b_in pins
//   gate_res_in   gate unit -> BIST     {not_a, not_b, buf, and, or, nand, nor, xor, xnor}
//   busy_out      BIST -> test/config   run in progress
//   done_out      BIST -> test/config   one-cycle completion pulse
//   pass_out      BIST -> test/config   sticky pass flag
//   fail_mask_out BIST -> test/config   per-gate mismatch accumulation
//   fail_vec_out  BIST -> test/config   per-vector mismatch flags
//
// Modports:
//   slave  - the BIST sequencer itself
//   master - the surrounding logic (test/config side plus the gate unit)

interface gate_bist_ctrl_if;
    logic       start_in;
    logic       a_out;
    logic       b_out;
    logic [8:0] gate_res_in;
    logic       busy_out;
    logic       done_out;
    logic       pass_out;
    logic [8:0] fail_mask_out;
    logic [3:0] fail_vec_out;

    modport slave (
        input  start_in,
        input  gate_res_in,
        output a_out,
        output b_out,
        output busy_out,
        output done_out,
        output pass_out,
        output fail_mask_out,
        output fail_vec_out
    );

    modport master (
        output start_in,
        output gate_res_in,
        input  a_out,
        input  b_out,
        input  busy_out,
        input  done_out,
        input  pass_out,
        input  fail_mask_out,
        input  fail_vec_out
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// rtl/gate_bist_ctrl.sv - built-in self-test sequencer for the two-input basic-gates unit
//
// Purpose: on a start request, walks the four (a,b) vectors 00, 01, 10, 11
// into the gate unit, holds each for SETTLE_CYCLES cycles plus one check
// cycle, compares the nine gate outputs against the truth table and reports
// per-gate / per-vector failures and an overall pass flag.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before its check cycle (1..255)
//
// Ports:
//   clk_in   rising-edge clock
//   rst_in   synchronous active-high reset
//   bus      gate_bist_ctrl_if.slave: start_in, gate_res_in in;
//            a_out, b_out, busy_out, done_out, pass_out, fail_mask_out,
//            fail_vec_out out (all outputs registered)

module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    gate_bist_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_idx_q, vec_idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [8:0] fail_mask_q, fail_mask_d;
    logic [3:0] fail_vec_q, fail_vec_d;

    logic       a_cur;
    logic       b_cur;
    logic [8:0] expected;
    logic [8:0] mismatch;

    // The vector index register is the a/b drive, so the pins change on the
    // same edge the index advances.
    assign a_cur = vec_idx_q[1];
    assign b_cur = vec_idx_q[0];

    always_comb begin
        expected = {~a_cur, ~b_cur, a_cur, a_cur & b_cur, a_cur | b_cur,
                    ~(a_cur & b_cur), ~(a_cur | b_cur), a_cur ^ b_cur,
                    ~(a_cur ^ b_cur)};
        mismatch = bus.gate_res_in ^ expected;
    end

    // State register and all datapath flops.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            vec_idx_q   <= 2'd0;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= 9'd0;
            fail_vec_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            vec_idx_q   <= vec_idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            fail_vec_q  <= fail_vec_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (vec_idx_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath logic.
    always_comb begin
        vec_idx_d   = vec_idx_q;
        cnt_d       = cnt_q;
        pass_d      = pass_q;
        fail_mask_d = fail_mask_q;
        fail_vec_d  = fail_vec_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_in) begin
                    vec_idx_d   = 2'd0;
                    cnt_d       = CNT_RELOAD;
                    pass_d      = 1'b0;
                    fail_mask_d = 9'd0;
                    fail_vec_d  = 4'd0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_CHECK: begin
                fail_mask_d             = fail_mask_q | mismatch;
                fail_vec_d[vec_idx_q]   = |mismatch;
                if (vec_idx_q != 2'd3) begin
                    vec_idx_d = vec_idx_q + 2'd1;
                    cnt_d     = CNT_RELOAD;
                end else begin
                    // Resolve pass on the last check so it is already valid
                    // while done_out is high.
                    pass_d = ((fail_mask_q | mismatch) == 9'd0);
                end
            end
            default: begin
            end
        endcase

        // Status flags are registered copies of where the FSM is heading.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign bus.a_out         = a_cur;
    assign bus.b_out         = b_cur;
    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.pass_out      = pass_q;
    assign bus.fail_mask_out = fail_mask_q;
    assign bus.fail_vec_out  = fail_vec_q;

endmodule
